// File: rtl/qif_neuron_array.sv
// ---------------------------------------------------------------------------
// qif_neuron_array
//
// Purpose:
//   CH quadratic integrate-and-fire neurons sharing one squarer/accumulator
//   datapath. A single-cycle `step` pulse starts a sweep.
//
//   The sweep advances every channel by one Euler step:
//       V <- sat(V + ((V*V) >> SQ_SHIFT) + B)
//
//   If the saturated sum reaches V_PEAK, the channel spikes and V is set to
//   V_RESET. Each channel costs two cycles: SQUARE, then ACCUM. A one-cycle
//   FINISH state publishes the spike vector and pulses `done`.
//
// Optional feature (macro QIF_REFRACTORY_EN):
//   When this macro is defined, every channel has a refractory counter. A
//   spike loads the counter with REF_STEPS. While the counter is nonzero:
//     - the channel's ACCUM step pins V at V_RESET,
//     - B is ignored,
//     - the channel cannot spike,
//     - the counter decrements once per sweep.
//   When the macro is undefined, no counters exist and REF_STEPS is unused.
//
// Ports:
//   clk          in   clock
//   rst          in   synchronous reset, active-high
//   step         in   single-cycle request to start one sweep
//                     (ignored unless IDLE)
//   b_in         in   per-channel signed input current,
//                     channel k at [k*WIDTH +: WIDTH]
//   busy         out  high while a sweep is in progress
//   done         out  one-cycle pulse when a sweep completes
//   spike_vec    out  spike flags of the most recent completed sweep
//   spike_valid  out  one-cycle pulse per spiking channel, during the sweep
//   spike_ch     out  channel index qualified by spike_valid
//   v_sel        in   channel select for membrane readback
//   v_out        out  registered membrane of channel v_sel
//                     (V_RESET if v_sel >= CH)
//
// Handshake:
//   `step` is a request with no back-pressure. It is accepted only in IDLE.
//   From acceptance until the `done` pulse, `busy` is high and further
//   requests are dropped, not queued.
// ---------------------------------------------------------------------------
module qif_neuron_array #(
    parameter int CH        = 4,
    parameter int WIDTH     = 8,
    parameter int SQ_SHIFT  = 6,
    parameter int V_PEAK    = 120,
    parameter int V_RESET   = -64,
    parameter int REF_STEPS = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    step,
    input  logic [CH*WIDTH-1:0]     b_in,
    output logic                    busy,
    output logic                    done,
    output logic [CH-1:0]           spike_vec,
    output logic                    spike_valid,
    output logic [$clog2(CH)-1:0]   spike_ch,
    input  logic [$clog2(CH)-1:0]   v_sel,
    output logic [WIDTH-1:0]        v_out
);

    localparam int CW = $clog2(CH);

    localparam logic signed [WIDTH-1:0]   VRST    = V_RESET[WIDTH-1:0];
    localparam logic signed [WIDTH+1:0]   PEAK    = V_PEAK[WIDTH+1:0];
    localparam logic [2*WIDTH-1:0]        SQ_MAX  = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH+1:0]   SUM_MAX = {3'b000, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH+1:0]   SUM_MIN = {3'b111, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SQUARE = 2'd1,
        S_ACCUM  = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t                   r_state;
    logic [CW-1:0]            r_ch;
    logic [2*WIDTH-1:0]       r_sq;
    logic signed [WIDTH-1:0]  r_v [CH];
    logic [CH-1:0]            r_spk_work;

    logic signed [WIDTH-1:0]   w_v_cur;
    logic signed [WIDTH-1:0]   w_b_cur;
    logic signed [2*WIDTH-1:0] w_sq_full;
    logic [2*WIDTH-1:0]        w_sq_shift;
    logic [WIDTH-1:0]          w_sq_sat;
    logic signed [WIDTH+1:0]   w_sum;
    logic signed [WIDTH+1:0]   w_sat_x;
    logic signed [WIDTH-1:0]   w_sat;
    logic                      w_spike;
    logic signed [WIDTH-1:0]   w_rd;
    logic                      w_last;

`ifdef QIF_REFRACTORY_EN
    localparam int RW = (REF_STEPS > 0) ? $clog2(REF_STEPS + 1) : 1;
    localparam logic [RW-1:0] REF_LOAD = RW'(REF_STEPS);

    logic [RW-1:0] r_ref [CH];
    logic [RW-1:0] w_ref_cur;
    logic          w_in_ref;
`else
    localparam int unused_ref_steps = REF_STEPS;
`endif

    // Operand select for the channel currently in the datapath.
    always_comb begin
        w_v_cur = VRST;
        w_b_cur = '0;
        for (int k = 0; k < CH; k++) begin
            if (r_ch == CW'(k)) begin
                w_v_cur = r_v[k];
                w_b_cur = b_in[k*WIDTH +: WIDTH];
            end
        end
    end

    // Membrane readback: channels beyond CH-1 read as V_RESET.
    always_comb begin
        w_rd = VRST;
        for (int k = 0; k < CH; k++) begin
            if (v_sel == CW'(k)) begin
                w_rd = r_v[k];
            end
        end
    end

`ifdef QIF_REFRACTORY_EN
    always_comb begin
        w_ref_cur = '0;
        for (int k = 0; k < CH; k++) begin
            if (r_ch == CW'(k)) begin
                w_ref_cur = r_ref[k];
            end
        end
    end
    assign w_in_ref = (w_ref_cur != '0);
`endif

    // Signed square is non-negative even for negative V; it fits 2*WIDTH bits
    // because the worst case (-2^(WIDTH-1))^2 is below 2^(2*WIDTH-1).
    assign w_sq_full  = w_v_cur * w_v_cur;

    // Scaled quadratic term, clamped to the largest positive membrane value.
    assign w_sq_shift = r_sq >> SQ_SHIFT;
    assign w_sq_sat   = (w_sq_shift > SQ_MAX) ? SQ_MAX[WIDTH-1:0] : w_sq_shift[WIDTH-1:0];

    // Two guard bits hold V + sq_s + B without overflow before clamping.
    assign w_sum   = {{2{w_v_cur[WIDTH-1]}}, w_v_cur}
                   + {2'b00, w_sq_sat}
                   + {{2{w_b_cur[WIDTH-1]}}, w_b_cur};
    assign w_sat_x = (w_sum > SUM_MAX) ? SUM_MAX :
                     (w_sum < SUM_MIN) ? SUM_MIN : w_sum;
    assign w_sat   = w_sat_x[WIDTH-1:0];
    assign w_spike = (w_sat_x >= PEAK);
    assign w_last  = (r_ch == CW'(CH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ch        <= '0;
            r_sq        <= '0;
            r_spk_work  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            spike_vec   <= '0;
            spike_valid <= 1'b0;
            spike_ch    <= '0;
            v_out       <= VRST;
            for (int k = 0; k < CH; k++) begin
                r_v[k] <= VRST;
`ifdef QIF_REFRACTORY_EN
                r_ref[k] <= '0;
`endif
            end
        end else begin
            done        <= 1'b0;
            spike_valid <= 1'b0;
            v_out       <= w_rd;

            case (r_state)
                S_IDLE: begin
                    if (step) begin
                        r_ch       <= '0;
                        r_spk_work <= '0;
                        busy       <= 1'b1;
                        r_state    <= S_SQUARE;
                    end
                end

                S_SQUARE: begin
                    r_sq    <= unsigned'(w_sq_full);
                    r_state <= S_ACCUM;
                end

                S_ACCUM: begin
`ifdef QIF_REFRACTORY_EN
                    if (w_in_ref) begin
                        r_v[r_ch]   <= VRST;
                        r_ref[r_ch] <= w_ref_cur - 1'b1;
                    end else if (w_spike) begin
                        r_v[r_ch]        <= VRST;
                        r_ref[r_ch]      <= REF_LOAD;
                        r_spk_work[r_ch] <= 1'b1;
                        spike_valid      <= 1'b1;
                        spike_ch         <= r_ch;
                    end else begin
                        r_v[r_ch] <= w_sat;
                    end
`else
                    if (w_spike) begin
                        r_v[r_ch]        <= VRST;
                        r_spk_work[r_ch] <= 1'b1;
                        spike_valid      <= 1'b1;
                        spike_ch         <= r_ch;
                    end else begin
                        r_v[r_ch] <= w_sat;
                    end
`endif
                    if (w_last) begin
                        r_state <= S_FINISH;
                    end else begin
                        r_ch    <= r_ch + 1'b1;
                        r_state <= S_SQUARE;
                    end
                end

                S_FINISH: begin
                    spike_vec <= r_spk_work;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    r_state   <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qif_neuron_array.sv
// ---------------------------------------------------------------------------
// tb_qif_neuron_array
//
// Directed bench for qif_neuron_array at default parameters
// (CH=4, WIDTH=8, SQ_SHIFT=6, V_PEAK=120, V_RESET=-64).
//
// Expected membrane values were worked by hand from
//     V' = clamp(V + min((V*V)>>6, 127) + B)
// with spike at >=120. Separate expectation columns cover builds with and
// without QIF_REFRACTORY_EN (REF_STEPS=3).
// ---------------------------------------------------------------------------
module tb_qif_neuron_array;

    logic        clk = 1'b0;
    logic        rst;
    logic        step;
    logic [31:0] b_in;
    logic        busy;
    logic        done;
    logic [3:0]  spike_vec;
    logic        spike_valid;
    logic [1:0]  spike_ch;
    logic [1:0]  v_sel;
    logic [7:0]  v_out;

    int checks   = 0;
    int failures = 0;

    qif_neuron_array dut (
        .clk         (clk),
        .rst         (rst),
        .step        (step),
        .b_in        (b_in),
        .busy        (busy),
        .done        (done),
        .spike_vec   (spike_vec),
        .spike_valid (spike_valid),
        .spike_ch    (spike_ch),
        .v_sel       (v_sel),
        .v_out       (v_out)
    );

    always #5 clk = ~clk;

    // Global watchdog in case the run itself wedges.
    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag,
                         input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic read_v(input logic [1:0] sel, output logic signed [31:0] val);
        v_sel = sel;
        @(negedge clk);
        val = $signed(v_out);
    endtask

    // Starts one sweep and returns:
    //   lat  - negedges from acceptance until done (-1 on timeout)
    //   msk  - set of channels seen on spike_valid/spike_ch
    //   nev  - number of spike_valid pulses
    // With hammer set, step is also held high for the eight cycles after
    // acceptance; those requests must be dropped.
    task automatic run_sweep(input  bit       hammer,
                             output int       lat,
                             output logic [3:0] msk,
                             output int       nev);
        int k;
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        check("busy_start", busy, 1);
        k    = 0;
        lat  = -1;
        msk  = '0;
        nev  = 0;
        step = hammer;
        while (1) begin
            if (spike_valid === 1'b1) begin
                msk[spike_ch] = 1'b1;
                nev++;
            end
            if (done === 1'b1) begin
                lat = k;
                break;
            end
            if (k >= 20) break;
            @(negedge clk);
            k++;
            step = hammer && (k < 8);
        end
        step = 1'b0;
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("busy_after_done", busy, 0);
    endtask

    int                 lat;
    int                 nev;
    int                 seen;
    logic [3:0]         msk;
    logic signed [31:0] v;
    int                 b1_tab [7];
    int                 exp_v0 [7];
    int                 exp_v1 [7];
    logic [3:0]         exp_msk [7];

    initial begin
        rst   = 1'b1;
        step  = 1'b0;
        b_in  = '0;
        v_sel = 2'd0;

        b1_tab  = '{100, 0, 5, 5, 5, 5, 5};
        exp_msk = '{4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
`ifdef QIF_REFRACTORY_EN
        exp_v0  = '{10, 21, 37, 68, -64, -64, -64};
        exp_v1  = '{100, -64, -64, -64, -64, 5, 10};
`else
        exp_v0  = '{10, 21, 37, 68, -64, 10, 21};
        exp_v1  = '{100, -64, 5, 10, 16, 25, 39};
`endif

        // Clock/reset.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state.
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_spike_vec", spike_vec, 0);
        check("rst_spike_valid", spike_valid, 0);
        for (int c = 0; c < 4; c++) begin
            read_v(c[1:0], v);
            check($sformatf("rst_v%0d", c), v, -64);
        end
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        check("idle_no_done", seen, 0);

        // Seven sweeps:
        //   ch0 integrates B=10 towards a spike on sweep 5;
        //   ch1 reaches 100 then spikes via the saturated square;
        //   ch2 pins at -128 with B=-128 (no wrap);
        //   ch3 settles at 0.
        // The last sweep also hammers step.
        for (int s = 0; s < 7; s++) begin
            b_in = {8'(0), 8'(-128), 8'(b1_tab[s]), 8'(10)};
            run_sweep(s == 6, lat, msk, nev);

            check($sformatf("s%0d_latency", s), lat, 9);
            check($sformatf("s%0d_spike_events", s), msk, exp_msk[s]);
            check($sformatf("s%0d_spike_count", s), nev, $countones(exp_msk[s]));
            check($sformatf("s%0d_spike_vec", s), spike_vec, exp_msk[s]);

            read_v(2'd0, v);
            check($sformatf("s%0d_v0", s), v, exp_v0[s]);
            read_v(2'd1, v);
            check($sformatf("s%0d_v1", s), v, exp_v1[s]);

            if (s == 0) begin
                read_v(2'd3, v);
                check("s0_v3", v, 0);
            end
            if (s == 1) begin
                read_v(2'd2, v);
                check("s1_v2_clamp", v, -128);
            end
        end

        // Reset in cycle 5 of a sweep aborts without a done pulse.
        b_in = {8'(50), 8'(50), 8'(50), 8'(50)};
        v_sel = 2'd1;
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_v_out", $signed(v_out), -64);

        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        check("abort_no_done", seen, 0);
        check("abort_spike_vec", spike_vec, 0);
        for (int c = 0; c < 4; c++) begin
            read_v(c[1:0], v);
            check($sformatf("abort_v%0d", c), v, -64);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/qif_neuron_array.md
Name: qif_neuron_array

Overview:
Parametrised successor to the single QIF neuron. Holds CH quadratic integrate-and-fire neurons of WIDTH-bit signed membrane state, time-multiplexed over one squarer/accumulator datapath. Each `step` pulse triggers one sweep that advances every channel by one Euler step and reports spikes as a vector and as per-event pulses. It sits between the input-current switches and the display/output mux of the top-level wrapper.

Parameters:
CH, 4, number of neuron channels (>=2)
WIDTH, 8, membrane and input-current width, two's complement
SQ_SHIFT, 6, right shift applied to V*V (quadratic gain 2^-SQ_SHIFT)
V_PEAK, 120, spike threshold (signed, fits WIDTH)
V_RESET, -64, post-spike membrane value and reset value (signed, fits WIDTH)
REF_STEPS, 3, refractory length in sweeps (used only with QIF_REFRACTORY_EN)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
step  in  1  single-cycle request to start one sweep
b_in  in  CH*WIDTH  per-channel input current B, channel k at bits [k*WIDTH +: WIDTH], signed
busy  out  1  high while a sweep is in progress
done  out  1  one-cycle pulse when a sweep completes
spike_vec  out  CH  spike flags of the most recent completed sweep
spike_valid  out  1  one-cycle pulse per spiking channel, during the sweep
spike_ch  out  max(1,$clog2(CH))  channel index qualified by spike_valid
v_sel  in  max(1,$clog2(CH))  channel select for membrane readback
v_out  out  WIDTH  membrane of channel v_sel, registered

Behaviour:
- One clock, synchronous active-high reset. On rst: all V[k]=V_RESET; refractory counters=0; state IDLE; busy=0, done=0, spike_vec=0, spike_valid=0, spike_ch=0, v_out=V_RESET.
- FSM states: IDLE, SQUARE, ACCUM, FINISH.
- IDLE: step=1 -> ch_idx=0, clear spike_vec working copy, go SQUARE, busy=1 next cycle.
- SQUARE: register sq = V[ch_idx]*V[ch_idx] (2*WIDTH unsigned); go ACCUM.
- ACCUM: sq_s = sq>>SQ_SHIFT, saturated to 2^(WIDTH-1)-1. sum = V + sq_s + B[ch_idx] in WIDTH+2 signed. sat = sum clamped to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - If sat >= V_PEAK: V[ch_idx] <= V_RESET, set working spike bit, spike_valid=1 and spike_ch=ch_idx on the next cycle.
  - Else V[ch_idx] <= sat.
  - If ch_idx==CH-1 -> FINISH, else ch_idx+1 -> SQUARE.
- FINISH: spike_vec <= working copy, done=1 for one cycle, busy=0, return to IDLE.
- Sweep latency: step sampled at edge t -> done high at cycle t+2*CH+1. Min spacing between accepted steps is 2*CH+2 cycles.
- step while busy or in FINISH: ignored, not queued.
- b_in sampled in the ACCUM cycle of each channel; mid-sweep changes affect only channels not yet accumulated.
- Saturation, not wrap: V never wraps sign. Negative V still squares positive (QIF fixed point of V^2+B).
- spike_vec holds its value until the next FINISH.
- v_out <= V[v_sel] every cycle, 1-cycle latency. Reflects in-progress writes. v_sel >= CH returns V_RESET.
- rst mid-sweep: abort immediately, full reset values, no done pulse.

Optional Feature:
QIF_REFRACTORY_EN: when defined, each channel has a counter loaded with REF_STEPS on spike. While nonzero, the ACCUM step holds V=V_RESET, ignores B, cannot spike, and decrements the counter once per sweep. When undefined, there are no counters and a spiking channel integrates normally on the next sweep. REF_STEPS is unused.

Test Plan:
- Reset then idle, B=0 on all channels -> v_out=-64 for every v_sel; busy=0, spike_vec=0, no done.
- Ch0: V preset via reset then forced path. B0=10, others 0, start from V=0 (V_RESET=0 build) -> after steps 1/2/3, V0=10/21/37; done exactly 9 cycles after each step (CH=4).
- Ch1 at V=100, B=0 -> sq_s saturates at 127, sum clamps 127 >= 120 -> spike_valid with spike_ch=1, V1=-64, spike_vec=4'b0010 at done.
- Ch2 with B=-128 from V=-128 -> sq_s=127 (256 before clamp), sum=-129 clamps to -128 -> no spike, no wrap.
- step pulses on cycles 1-8 of a sweep are ignored, and rst asserted in cycle 5 of a sweep -> no done, all V=-64, busy=0 next cycle.
- With QIF_REFRACTORY_EN, REF_STEPS=3, ch1 B=127 -> spike, then V1 stays -64 for 3 sweeps with no spikes, and integrates again on sweep 4. Without the macro, ch1 integrates on the very next sweep.
